multi_interval_timer: RTL

Parametrised successor to the single-channel Avalon interval timer: `NUM_CH` independent down-counters of `CNT_W` bits behind one Avalon-MM slave. Each channel has an optional per-channel prescaler, one-shot or continuous mode, snapshot capture and a sticky timeout flag. The per-channel interrupts are ORed into a single `irq`. The block sits on the SoC bus as a drop-in system tick, or as a multi-rate tick source for the game loop and audio timing.

---
 rtl/multi_interval_timer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_interval_timer.sv
// multi_interval_timer: NUM_CH independent down-counters behind one Avalon-MM
// slave. Each channel has a period, a snapshot register, a sticky timeout
// flag, one-shot/continuous mode and an interrupt enable.
// Optional feature macro: TIMER_PRESCALE_EN adds a per-channel prescaler.
// Without it, every running cycle is a tick.
module multi_interval_timer #(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 16,
  parameter logic [31:0] RESET_PERIOD = 32'd49999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_SNAP     = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  logic [NUM_CH-1:0][CNT_W-1:0] period_q, period_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] snap_q, snap_d;
  logic [NUM_CH-1:0]            running_q, running_d;
  logic [NUM_CH-1:0]            timeout_q, timeout_d;
  logic [NUM_CH-1:0]            cont_q, cont_d;
  logic [NUM_CH-1:0]            ito_q, ito_d;
`ifdef TIMER_PRESCALE_EN
  logic [NUM_CH-1:0][PRE_W-1:0] prescale_q, prescale_d;
  logic [NUM_CH-1:0][PRE_W-1:0] pre_q, pre_d;
`endif
  logic [31:0]                  readdata_q, readdata_d;

  logic                         wr_s;
  logic                         pending_any_s;
  logic [NUM_CH-1:0]            sel_s;
  logic [NUM_CH-1:0]            tick_s;
  logic [NUM_CH-1:0]            fire_s;
  logic [NUM_CH-1:0][31:0]      ch_word_s;

  assign wr_s          = chipselect & ~write_n;
  assign pending_any_s = |timeout_q;
  assign irq           = |(timeout_q & ito_q);
  assign readdata      = readdata_q;

  // Per-channel write select, tick and "counter wraps this cycle" decode.
  always_comb begin
    sel_s  = '0;
    tick_s = '0;
    fire_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_s[c]  = wr_s && (address[5:3] == 3'(c));
`ifdef TIMER_PRESCALE_EN
      tick_s[c] = running_q[c] && (pre_q[c] == '0);
`else
      tick_s[c] = running_q[c];
`endif
      fire_s[c] = tick_s[c] && (cnt_q[c] == '0);
    end
  end

  // Channel next state: counting first, then the bus write overrides it.
  always_comb begin
    period_d   = period_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    running_d  = running_q;
    timeout_d  = timeout_q;
    cont_d     = cont_q;
    ito_d      = ito_q;
`ifdef TIMER_PRESCALE_EN
    pre_d      = pre_q;
    prescale_d = prescale_q;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef TIMER_PRESCALE_EN
      if (running_q[c]) begin
        if (pre_q[c] == '0) begin
          pre_d[c] = prescale_q[c];
        end else begin
          pre_d[c] = pre_q[c] - PRE_W'(1);
        end
      end else begin
        pre_d[c] = pre_q[c];
      end
`endif
      if (tick_s[c]) begin
        if (cnt_q[c] == '0) begin
          cnt_d[c]     = period_q[c];
          timeout_d[c] = 1'b1;
          // a tick implies running, so one-shot stops and continuous keeps going
          running_d[c] = cont_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end
      end else begin
        cnt_d[c] = cnt_q[c];
      end

      if (sel_s[c]) begin
        case (address[2:0])
          REG_STATUS: begin
            // a timeout firing in the same cycle beats the clear
            timeout_d[c] = fire_s[c];
          end
          REG_CONTROL: begin
            cont_d[c]    = writedata[1];
            ito_d[c]     = writedata[0];
            // start beats stop when both strobes are set
            running_d[c] = writedata[2] | (running_d[c] & ~writedata[3]);
          end
          REG_PERIOD: begin
            period_d[c]  = writedata[CNT_W-1:0];
            cnt_d[c]     = writedata[CNT_W-1:0];
            running_d[c] = 1'b0;
            // the forced reload suppresses a timeout firing this cycle
            timeout_d[c] = timeout_q[c];
`ifdef TIMER_PRESCALE_EN
            pre_d[c]     = prescale_q[c];
`endif
          end
          REG_SNAP: begin
            // capture the value before this cycle's decrement
            snap_d[c] = cnt_q[c];
          end
          REG_PRESCALE: begin
`ifdef TIMER_PRESCALE_EN
            prescale_d[c] = writedata[PRE_W-1:0];
`endif
          end
          default: begin
          end
        endcase
      end else begin
        // no bus write to this channel: counting result stands
      end
    end
  end

  // Register view of each channel for the currently addressed register.
  always_comb begin
    ch_word_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (address[2:0])
        REG_STATUS:   ch_word_s[c][2:0] = {pending_any_s, running_q[c], timeout_q[c]};
        REG_CONTROL:  ch_word_s[c][1:0] = {cont_q[c], ito_q[c]};
        REG_PERIOD:   ch_word_s[c][CNT_W-1:0] = period_q[c];
        REG_SNAP:     ch_word_s[c][CNT_W-1:0] = snap_q[c];
`ifdef TIMER_PRESCALE_EN
        REG_PRESCALE: ch_word_s[c][PRE_W-1:0] = prescale_q[c];
`endif
        default:      ch_word_s[c] = 32'd0;
      endcase
    end
  end

  // Read mux: channels outside 0..NUM_CH-1 never match and so read 0.
  always_comb begin
    readdata_d = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      readdata_d = readdata_d | ((address[5:3] == 3'(c)) ? ch_word_s[c] : 32'd0);
    end
  end

  // State and read-data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q   <= {NUM_CH{RESET_PERIOD[CNT_W-1:0]}};
      cnt_q      <= {NUM_CH{RESET_PERIOD[CNT_W-1:0]}};
      snap_q     <= '0;
      running_q  <= '0;
      timeout_q  <= '0;
      cont_q     <= '0;
      ito_q      <= '0;
`ifdef TIMER_PRESCALE_EN
      prescale_q <= '0;
      pre_q      <= '0;
`endif
      readdata_q <= 32'd0;
    end else begin
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      running_q  <= running_d;
      timeout_q  <= timeout_d;
      cont_q     <= cont_d;
      ito_q      <= ito_d;
`ifdef TIMER_PRESCALE_EN
      prescale_q <= prescale_d;
      pre_q      <= pre_d;
`endif
      readdata_q <= readdata_d;
    end
  end

endmodule
